// File: rtl/md_unit_pkg.sv
// Shared mult/div opcode definitions and state encoding for md_unit.
package md_unit_pkg;

    // mdop encodings, shared with the control decoder
    typedef enum logic [3:0] {
        MD_NONE  = 4'b0000,
        MD_MULT  = 4'b0001,
        MD_MULTU = 4'b0010,
        MD_DIV   = 4'b0011,
        MD_DIVU  = 4'b0100,
        MD_MTHI  = 4'b0101,
        MD_MTLO  = 4'b0110,
        MD_MFHI  = 4'b0111,
        MD_MFLO  = 4'b1000
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // True for the operations that occupy the unit for several cycles
    function automatic logic md_is_long(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Results are computed behaviourally at the accept edge and committed to
// HI/LO after a fixed latency modelled by a down-counter.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] md_input1,
    input  logic [31:0] md_input2,
    input  logic [3:0]  mdop,
    input  logic        start,
    input  logic        md_kill,
    output logic        busy,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e          r_state;
    logic               r_busy;
    logic [31:0]        r_cnt;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_wr;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_accept;
    logic               w_long;
    logic signed [63:0] w_a_s64;
    logic signed [63:0] w_b_s64;
    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic [31:0]        w_dvs_s;
    logic [31:0]        w_dvs_u;
    logic signed [31:0] w_q_s;
    logic signed [31:0] w_r_s;
    logic [31:0]        w_q_u;
    logic [31:0]        w_r_u;
    logic [63:0]        w_res;
    logic               w_res_wr;
    logic [31:0]        w_cnt_load;

    assign w_accept = start && !md_kill && !r_busy;
    assign w_long   = md_is_long(mdop);

    assign w_a_s64  = {{32{md_input1[31]}}, md_input1};
    assign w_b_s64  = {{32{md_input2[31]}}, md_input2};
    assign w_prod_s = w_a_s64 * w_b_s64;
    assign w_prod_u = {32'd0, md_input1} * {32'd0, md_input2};

    // Divisor is forced to 1 for divide-by-zero (result discarded) and for
    // INT_MIN / -1, where dividing by 1 yields exactly the required
    // quotient 0x80000000 and remainder 0 without signed overflow.
    assign w_div_zero = (md_input2 == 32'd0);
    assign w_div_ovf  = (md_input1 == 32'h8000_0000) && (md_input2 == 32'hFFFF_FFFF);
    assign w_dvs_s    = (w_div_zero || w_div_ovf) ? 32'd1 : md_input2;
    assign w_dvs_u    = w_div_zero ? 32'd1 : md_input2;
    assign w_q_s      = $signed(md_input1) / $signed(w_dvs_s);
    assign w_r_s      = $signed(md_input1) % $signed(w_dvs_s);
    assign w_q_u      = md_input1 / w_dvs_u;
    assign w_r_u      = md_input1 % w_dvs_u;

    // Select the 64-bit {HI,LO} result and latency for the requested op
    always_comb begin
        w_res      = '0;
        w_res_wr   = 1'b0;
        w_cnt_load = 32'(DIV_CYCLES);
        case (mdop)
            MD_MULT: begin
                w_res      = w_prod_s;
                w_res_wr   = 1'b1;
                w_cnt_load = 32'(MULT_CYCLES);
            end
            MD_MULTU: begin
                w_res      = w_prod_u;
                w_res_wr   = 1'b1;
                w_cnt_load = 32'(MULT_CYCLES);
            end
            MD_DIV: begin
                w_res    = {w_r_s, w_q_s};
                w_res_wr = !w_div_zero;
            end
            MD_DIVU: begin
                w_res    = {w_r_u, w_q_u};
                w_res_wr = !w_div_zero;
            end
            default: begin
                w_res      = '0;
                w_res_wr   = 1'b0;
                w_cnt_load = 32'(DIV_CYCLES);
            end
        endcase
    end

    // Control FSM: accept, count down latency, commit pending result to HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_wr <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_long) begin
                            r_state   <= ST_RUN;
                            r_busy    <= 1'b1;
                            r_cnt     <= w_cnt_load;
                            r_pend_hi <= w_res[63:32];
                            r_pend_lo <= w_res[31:0];
                            r_pend_wr <= w_res_wr;
                        end else if (mdop == MD_MTHI) begin
                            r_hi <= md_input1;
                        end else if (mdop == MD_MTLO) begin
                            r_lo <= md_input1;
                        end
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - 32'd1;
                    if (r_cnt == 32'd1) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        if (r_pend_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Move-from read port: plain register read, no bypass
    always_comb begin
        md_out = '0;
        case (mdop)
            MD_MFHI: md_out = r_hi;
            MD_MFLO: md_out = r_lo;
            default: md_out = '0;
        endcase
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
